// File: rtl/adex_pkg.sv
// Shared constants, saturation helper and FSM state type for the AdEx neuron scheduler.
package adex_pkg;

  localparam logic signed [15:0] V_PEAK  = 16'sd20;
  localparam logic signed [15:0] V_RESET = -16'sd65;
  localparam logic signed [15:0] E_L     = -16'sd70;
  localparam logic signed [15:0] B_INC   = 16'sd8;
  localparam logic signed [15:0] A_GAIN  = 16'sd2;
  localparam int                 TAU_SHIFT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CALC,
    S_WRITE,
    S_SPIKE,
    S_FIN
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage

// File: rtl/adex_adapt_update.sv
// Adaptation current update: subthreshold drift toward A_GAIN*(v-E_L) plus the spike increment.
module adex_adapt_update
  import adex_pkg::*;
(
  input  logic signed [15:0] v,
  input  logic signed [15:0] u,
  output logic signed [15:0] u_new,
  output logic signed [15:0] u_spk
);

  logic signed [31:0] drive;
  logic signed [31:0] u_sum;
  logic signed [31:0] u_inc;

  always_comb begin
    drive = 32'(A_GAIN) * (32'(v) - 32'(E_L)) - 32'(u);
    u_sum = 32'(u) + (drive >>> TAU_SHIFT);
    u_new = sat16(u_sum);
    // Increment applies to the already saturated u_new, then saturates again.
    u_inc = 32'(u_new) + 32'(B_INC);
    u_spk = sat16(u_inc);
  end

endmodule

// File: rtl/adex_neuron_scheduler.sv
// Walks every neuron once per timestep through the shared v datapath and emits spike events.
// state | meaning: IDLE wait start | FETCH current read | LOAD operands | CALC sample result
//                  WRITE write-back | SPIKE wait spike_ready | FIN done pulse
module adex_neuron_scheduler
  import adex_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [15:0]      dt,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        cur_idx,
  output logic                    cur_rd,
  input  logic signed [15:0]      cur_I,
  output logic signed [15:0]      dp_v,
  output logic signed [15:0]      dp_u,
  output logic signed [15:0]      dp_I,
  output logic signed [15:0]      dp_dt,
  input  logic signed [31:0]      dp_v_next,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  input  logic                    spike_ready,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [15:0]      rd_v,
  output logic signed [15:0]      rd_u
);

  state_t state, state_nx;

  logic [IDX_W-1:0]   idx;
  logic signed [15:0] dt_q;
  logic signed [15:0] v_mem [N_NEURONS];
  logic signed [15:0] u_mem [N_NEURONS];
  logic signed [15:0] vs_q, un_q, us_q;
  logic               spk_q;
  logic signed [15:0] vs_w, un_w, us_w;
  logic               last, advance;

  adex_adapt_update u_adapt (
    .v     (dp_v),
    .u     (dp_u),
    .u_new (un_w),
    .u_spk (us_w)
  );

  assign vs_w    = sat16(dp_v_next);
  assign last    = (idx == IDX_W'(N_NEURONS - 1));
  assign cur_idx = idx;
  assign rd_v    = v_mem[rd_idx];
  assign rd_u    = u_mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    cur_rd   = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        cur_rd   = 1'b1;
        state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: begin
        if (spk_q) state_nx = S_SPIKE;
        else       advance  = 1'b1;
      end
      S_SPIKE: advance = spike_ready;
      S_FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (advance) state_nx = last ? S_FIN : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      dt_q        <= '0;
      dp_v        <= '0;
      dp_u        <= '0;
      dp_I        <= '0;
      dp_dt       <= '0;
      vs_q        <= '0;
      un_q        <= '0;
      us_q        <= '0;
      spk_q       <= 1'b0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= E_L;
        u_mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dt_q <= dt;
          idx  <= '0;
        end
        S_LOAD: begin
          dp_v  <= v_mem[idx];
          dp_u  <= u_mem[idx];
          dp_I  <= cur_I;
          dp_dt <= dt_q;
        end
        S_CALC: begin
          vs_q  <= vs_w;
          un_q  <= un_w;
          us_q  <= us_w;
          spk_q <= (vs_w >= V_PEAK);
        end
        S_WRITE: begin
          if (spk_q) begin
            v_mem[idx]  <= V_RESET;
            u_mem[idx]  <= us_q;
            spike_valid <= 1'b1;
            spike_idx   <= idx;
          end else begin
            v_mem[idx] <= vs_q;
            u_mem[idx] <= un_q;
          end
        end
        S_SPIKE: if (spike_ready) spike_valid <= 1'b0;
        default: ;
      endcase
      if (advance && !last) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_adex_neuron_scheduler.sv
// Self-checking bench: bench-side datapath, per-sweep neuron model, vector table and random sweeps.
module tb_adex_neuron_scheduler;

  localparam int N = 16;

  logic               clk, rst_n, start, busy, done, cur_rd, spike_valid, spike_ready;
  logic signed [15:0] dt, cur_I, dp_v, dp_u, dp_I, dp_dt, rd_v, rd_u;
  logic signed [31:0] dp_v_next;
  logic [3:0]         cur_idx, spike_idx, rd_idx;

  logic signed [31:0] ovr     [N];
  bit                 ovr_en  [N];
  logic signed [15:0] cur_tab [N];

  int mv [N];
  int mu [N];
  int exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_spk_seen = 0;
  int lat;

  typedef struct {
    logic signed [31:0] vnext;
    int                 exp_v;
    int                 exp_spk;
  } vec_t;
  vec_t tbl [9];

  adex_neuron_scheduler #(.N_NEURONS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dt(dt), .busy(busy), .done(done),
    .cur_idx(cur_idx), .cur_rd(cur_rd), .cur_I(cur_I),
    .dp_v(dp_v), .dp_u(dp_u), .dp_I(dp_I), .dp_dt(dp_dt), .dp_v_next(dp_v_next),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .rd_idx(rd_idx), .rd_v(rd_v), .rd_u(rd_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench stands in for the shared datapath: v + I*dt unless a neuron is overridden.
  always_comb begin
    cur_I = cur_tab[cur_idx];
    if (ovr_en[cur_idx]) dp_v_next = ovr[cur_idx];
    else                 dp_v_next = 32'(dp_v) + 32'(dp_I) * 32'(dp_dt);
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = -70;
      mu[i] = 0;
    end
  endtask

  task automatic model_sweep(input int dtv);
    int vn, vs, un;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      vn = ovr_en[i] ? int'(ovr[i]) : mv[i] + int'(cur_tab[i]) * dtv;
      vs = sat(vn);
      un = sat(mu[i] + ((2 * (mv[i] + 70) - mu[i]) >>> 4));
      if (vs >= 20) begin
        mv[i] = -65;
        mu[i] = sat(un + 8);
        exp_q.push_back(i);
      end else begin
        mv[i] = vs;
        mu[i] = un;
      end
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) begin
      ovr_en[i] = 1'b1;
      ovr[i]    = 32'(v);
      cur_tab[i] = '0;
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < N; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("rd_v[%0d]", i), rd_v, mv[i]);
      check($sformatf("rd_u[%0d]", i), rd_u, mu[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_v(input int i, output int v, output int u);
    rd_idx = 4'(i);
    #1;
    v = rd_v;
    u = rd_u;
  endtask

  // stall_mode < 0: random backpressure per spike, else fixed number of not-ready cycles.
  task automatic sweep(input int dtv, input int stall_mode, input bit mid_start,
                       input bit fin_start, output int cycles);
    int extra = 0, k = 0, stall_left = 0;
    bit in_spike = 0;
    model_sweep(dtv);
    dt = 16'(dtv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dt = 16'($urandom);
    cycles = 1;
    check("busy_rise", busy, 1);
    while (!done && cycles < 3000) begin
      if (in_spike && spike_ready) begin
        in_spike = 0;
        check("valid_drop", spike_valid, 0);
      end
      if (spike_valid && !in_spike) begin
        in_spike = 1;
        stall_left = (stall_mode < 0) ? int'($urandom_range(0, 4)) : stall_mode;
        extra += stall_left + 1;
        check("spike_idx", spike_idx, (k < exp_q.size()) ? exp_q[k] : -1);
        k++;
      end
      if (in_spike) begin
        check("spike_hold_valid", spike_valid, 1);
        check("spike_hold_idx", spike_idx, (k - 1 < exp_q.size()) ? exp_q[k-1] : -1);
        spike_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        spike_ready = 1'b0;
      end
      start = (mid_start && cycles == 21);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    spike_ready = 1'b0;
    check("done_seen", done, 1);
    check("latency", cycles, 65 + extra);
    check("busy_at_done", busy, 0);
    check("spike_count", k, exp_q.size());
    check("dp_dt_latched", dp_dt, dtv);
    check("dp_I_last", dp_I, cur_tab[N-1]);
    n_spk_seen = k;
    if (fin_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    check_state();
  endtask

  initial begin
    int v, u, lat0, wait_c;
    rst_n = 1'b0; start = 1'b0; dt = '0; spike_ready = 1'b0; rd_idx = '0;
    set_all(-68);
    model_reset();
    tbl[0] = '{-32'sd68,     -68,    0};
    tbl[1] = '{32'sd19,      19,     0};
    tbl[2] = '{32'sd20,      -65,    1};
    tbl[3] = '{32'sd25,      -65,    1};
    tbl[4] = '{32'sd100000,  -65,    1};
    tbl[5] = '{-32'sd100000, -32768, 0};
    tbl[6] = '{32'sd32767,   -65,    1};
    tbl[7] = '{-32'sd32768,  -32768, 0};
    tbl[8] = '{32'sd32768,   -65,    1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_cur_rd", cur_rd, 0);
    check("rst_dp_v", dp_v, 0);
    rst_n = 1'b1;
    check_state();

    sweep(1, 0, 0, 0, lat);
    check("lat_no_spike", lat, 65);

    ovr[3] = 32'sd25;
    sweep(1, 0, 0, 0, lat0);
    read_v(3, v, u);
    check("spk3_v", v, -65);
    check("spk3_u", u, 8);
    check("lat_one_spike", lat0, 66);
    @(posedge clk); #1;

    sweep(1, 10, 0, 0, lat);
    check("lat_stall10", lat, lat0 + 10);
    ovr[3] = -32'sd68;

    for (int t = 0; t < 9; t++) begin
      ovr[5] = tbl[t].vnext;
      sweep(2, 0, 0, 0, lat);
      read_v(5, v, u);
      check($sformatf("tbl%0d_v", t), v, tbl[t].exp_v);
      check($sformatf("tbl%0d_spk", t), n_spk_seen, tbl[t].exp_spk);
      @(posedge clk); #1;
    end
    ovr[5] = -32'sd68;

    // start during the sweep and in the FIN cycle must both be dropped
    sweep(1, 0, 1, 1, lat);
    check("lat_start_busy", lat, 65);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        ovr_en[i]  = ($urandom_range(0, 4) == 0);
        ovr[i]     = 32'($urandom_range(0, 80000)) - 32'sd40000;
        cur_tab[i] = 16'($urandom_range(0, 40)) - 16'sd20;
      end
      sweep(int'($urandom_range(0, 3)), -1, 0, 0, lat);
    end

    set_all(-68);
    dt = 16'sd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_c = 0;
    while (cur_idx != 4'd7 && wait_c < 200) begin
      @(posedge clk); #1;
      wait_c++;
    end
    check("reach_idx7", cur_idx, 7);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cur_rd", cur_rd, 0);
    check("midrst_cur_idx", cur_idx, 0);
    @(posedge clk); #1;
    check("midrst_no_done", done, 0);
    rst_n = 1'b1;
    check_state();
    sweep(1, 0, 0, 0, lat);
    check("lat_after_rst", lat, 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
